// File: rtl/pick_seq_pkg.sv
// Shared definitions for the pick-and-place sequencer.
// Contents:
//   state_t     - sequencer states, in job order, followed by the recovery states
//   HOME_Y      - arm Y reach when stowed (L1+L2), Q16.16 cm
//   PARK_X/Y    - arm park pose used while the table returns, Q16.16 cm
//   dwellLimit  - maps a programmed dwell to the cycle count it really occupies
package pick_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HOME,
        MOVE,
        OPEN,
        REACH,
        GRASP,
        PARK,
        RETURN,
        RELEASE,
        STOW,
        DONE,
        RECOVER,
        FAULT
    } state_t;

    localparam logic [31:0] HOME_Y = 32'h0019_6666;
    localparam logic [31:0] PARK_X = 32'd289057;
    localparam logic [31:0] PARK_Y = 32'd1639325;

    // A dwell state always lasts at least one cycle, so a programmed 0 is
    // treated as 1.
    function automatic logic [31:0] dwellLimit(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step timer shared by the dwell and table-timeout logic.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_clear       - restart the count at 0 on the next edge (state entry)
//   i_en          - count enable
//   i_limit       - number of cycles the current step may last
//   o_count       - cycles spent in the current step (0 in the entry cycle)
//   o_expired     - high in the last cycle of a step of i_limit cycles
module step_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [31:0] i_limit,
    output logic [31:0] o_count,
    output logic        o_expired
);

    logic [31:0] r_count;

    // The count saturates rather than wrapping, so a stuck step can never
    // look freshly started again.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Compared one cycle early so the owning state leaves on the edge that
    // ends its i_limit-th cycle; 33 bits keep the +1 from overflowing.
    assign o_expired = ({1'b0, r_count} + 33'd1) >= {1'b0, i_limit};
    assign o_count   = r_count;

endmodule

// File: rtl/pick_seq_ctrl.sv
// Sequencer for one pick-and-place job: table home, table move to z, open,
// reach to (x,y), grasp, park, table return, release, stow, done.
// Ports:
//   i_clk, i_rst                  - clock, synchronous active-high reset
//   i_job_valid/o_job_ready       - job handshake, i_job_x/y/z target (Q16.16)
//   i_abort                       - level; cancel job (or leave FAULT)
//   i_table_busy                  - slide table moving
//   o_table_start/o_table_back    - one-cycle table command pulses
//   o_table_dest                  - table destination
//   o_arm_x/o_arm_y/o_arm_en      - arm IK target and follow enable
//   o_grip                        - 1 = gripper open
//   o_busy/o_done/o_job_clr/o_err - status
module pick_seq_ctrl #(
    parameter logic [31:0] T_ARM   = 32'd50_000_000,
    parameter logic [31:0] T_GRIP  = 32'd25_000_000,
    parameter logic [31:0] T_TABLE = 32'd500_000_000,
    parameter logic [7:0]  T_BLANK = 8'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_job_valid,
    output logic        o_job_ready,
    input  logic [31:0] i_job_x,
    input  logic [31:0] i_job_y,
    input  logic [31:0] i_job_z,
    input  logic        i_abort,
    input  logic        i_table_busy,
    output logic        o_table_start,
    output logic        o_table_back,
    output logic [31:0] o_table_dest,
    output logic [31:0] o_arm_x,
    output logic [31:0] o_arm_y,
    output logic        o_arm_en,
    output logic        o_grip,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_job_clr,
    output logic        o_err
);

    import pick_seq_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_job_x, r_job_y, r_job_z;
    logic        r_job_ready, r_table_start, r_table_back, r_arm_en, r_grip;
    logic        r_busy, r_done, r_err;
    logic [31:0] r_table_dest, r_arm_x, r_arm_y;

    logic        w_accept, w_enter, w_table_ok, w_expired, w_abortable;
    logic [31:0] w_limit, w_count;
    logic        w_job_ready, w_table_start, w_table_back, w_grip;
    logic        w_busy, w_done, w_err;
    logic [31:0] w_table_dest, w_arm_x, w_arm_y;

    // Every state change restarts the timer, so each step measures its own
    // dwell or timeout from its entry edge (the pulse cycle for table steps).
    step_timer u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_enter),
        .i_en      (1'b1),
        .i_limit   (w_limit),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    // Timer limit for the state currently occupied; table steps use the
    // move timeout.
    always_comb begin
        w_limit = T_TABLE;
        case (r_state)
            OPEN, GRASP, RELEASE: w_limit = dwellLimit(T_GRIP);
            REACH, PARK, STOW:    w_limit = dwellLimit(T_ARM);
            default:              w_limit = T_TABLE;
        endcase
    end

    assign w_accept    = i_job_valid && r_job_ready && (r_state == IDLE);
    assign w_table_ok  = (w_count >= {24'd0, T_BLANK}) && !i_table_busy;
    assign w_abortable = (r_state != IDLE) && (r_state != FAULT) && (r_state != RECOVER);
    assign w_enter     = (w_next_state != r_state);

    // Next-state logic: table steps finish on an idle table after blanking
    // (taking precedence over a simultaneous timeout); abort overrides
    // everything, including a timeout in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = HOME;
            HOME:    if (w_table_ok) w_next_state = MOVE;
                     else if (w_expired) w_next_state = FAULT;
            MOVE:    if (w_table_ok) w_next_state = OPEN;
                     else if (w_expired) w_next_state = FAULT;
            OPEN:    if (w_expired) w_next_state = REACH;
            REACH:   if (w_expired) w_next_state = GRASP;
            GRASP:   if (w_expired) w_next_state = PARK;
            PARK:    if (w_expired) w_next_state = RETURN;
            RETURN:  if (w_table_ok) w_next_state = RELEASE;
                     else if (w_expired) w_next_state = FAULT;
            RELEASE: if (w_expired) w_next_state = STOW;
            STOW:    if (w_expired) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            RECOVER: if (w_table_ok) w_next_state = IDLE;
                     else if (w_expired) w_next_state = FAULT;
            FAULT:   if (i_abort) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (i_abort && w_abortable) begin
            w_next_state = RECOVER;
        end
    end

    // Output values for the coming cycle. Actuator outputs hold unless the
    // state being entered sets them; pulses fire only on entry.
    always_comb begin
        w_job_ready   = (w_next_state == IDLE);
        w_busy        = (w_next_state != IDLE);
        w_err         = (w_next_state == FAULT);
        w_table_start = 1'b0;
        w_table_back  = 1'b0;
        w_done        = 1'b0;
        w_table_dest  = r_table_dest;
        w_arm_x       = r_arm_x;
        w_arm_y       = r_arm_y;
        w_grip        = r_grip;
        if (w_enter) begin
            case (w_next_state)
                HOME, RETURN: w_table_back = 1'b1;
                MOVE: begin
                    w_table_start = 1'b1;
                    w_table_dest  = r_job_z;
                end
                OPEN, RELEASE: w_grip = 1'b1;
                REACH: begin
                    w_arm_x = r_job_x;
                    w_arm_y = r_job_y;
                end
                GRASP: w_grip = 1'b0;
                PARK: begin
                    w_arm_x = PARK_X;
                    w_arm_y = PARK_Y;
                end
                RECOVER: begin
                    w_table_back = 1'b1;
                    w_grip       = 1'b0;
                    w_arm_x      = '0;
                    w_arm_y      = HOME_Y;
                end
                STOW, FAULT: begin
                    w_grip  = 1'b0;
                    w_arm_x = '0;
                    w_arm_y = HOME_Y;
                end
                DONE: w_done = 1'b1;
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output registers and the job latch; reset drops any in-flight pulse
    // and discards the latched job.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_job_ready   <= 1'b0;
            r_table_start <= 1'b0;
            r_table_back  <= 1'b0;
            r_table_dest  <= '0;
            r_arm_x       <= '0;
            r_arm_y       <= HOME_Y;
            r_arm_en      <= 1'b1;
            r_grip        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_job_x       <= '0;
            r_job_y       <= '0;
            r_job_z       <= '0;
        end else begin
            r_job_ready   <= w_job_ready;
            r_table_start <= w_table_start;
            r_table_back  <= w_table_back;
            r_table_dest  <= w_table_dest;
            r_arm_x       <= w_arm_x;
            r_arm_y       <= w_arm_y;
            r_arm_en      <= 1'b1;
            r_grip        <= w_grip;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_err         <= w_err;
            if (w_accept) begin
                r_job_x <= i_job_x;
                r_job_y <= i_job_y;
                r_job_z <= i_job_z;
            end
        end
    end

    assign o_job_ready   = r_job_ready;
    assign o_table_start = r_table_start;
    assign o_table_back  = r_table_back;
    assign o_table_dest  = r_table_dest;
    assign o_arm_x       = r_arm_x;
    assign o_arm_y       = r_arm_y;
    assign o_arm_en      = r_arm_en;
    assign o_grip        = r_grip;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_job_clr     = r_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_pick_seq_ctrl.sv
// Bench for pick_seq_ctrl. DUT A: T_ARM=5, T_GRIP=3, T_TABLE=40, T_BLANK=2.
// DUT B shares A's inputs with zero dwells to check the one-cycle minimum.
module tb_pick_seq_ctrl;
    import pick_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jobValid = 1'b0;
    logic        abortReq = 1'b0;
    logic        tableBusy = 1'b0;
    logic [31:0] jobX = '0, jobY = '0, jobZ = '0;

    logic        aReady, aStart, aBack, aArmEn, aGrip, aBusy, aDone, aClr, aErr;
    logic [31:0] aDest, aArmX, aArmY;
    logic        bReady, bStart, bBack, bArmEn, bGrip, bBusy, bDone, bClr, bErr;
    logic [31:0] bDest, bArmX, bArmY;

    pick_seq_ctrl #(.T_ARM(32'd5), .T_GRIP(32'd3), .T_TABLE(32'd40), .T_BLANK(8'd2)) dutA (
        .i_clk(clock), .i_rst(reset), .i_job_valid(jobValid), .o_job_ready(aReady),
        .i_job_x(jobX), .i_job_y(jobY), .i_job_z(jobZ), .i_abort(abortReq),
        .i_table_busy(tableBusy), .o_table_start(aStart), .o_table_back(aBack),
        .o_table_dest(aDest), .o_arm_x(aArmX), .o_arm_y(aArmY), .o_arm_en(aArmEn),
        .o_grip(aGrip), .o_busy(aBusy), .o_done(aDone), .o_job_clr(aClr), .o_err(aErr)
    );

    pick_seq_ctrl #(.T_ARM(32'd0), .T_GRIP(32'd0), .T_TABLE(32'd40), .T_BLANK(8'd2)) dutB (
        .i_clk(clock), .i_rst(reset), .i_job_valid(jobValid), .o_job_ready(bReady),
        .i_job_x(jobX), .i_job_y(jobY), .i_job_z(jobZ), .i_abort(abortReq),
        .i_table_busy(tableBusy), .o_table_start(bStart), .o_table_back(bBack),
        .o_table_dest(bDest), .o_arm_x(bArmX), .o_arm_y(bArmY), .o_arm_en(bArmEn),
        .o_grip(bGrip), .o_busy(bBusy), .o_done(bDone), .o_job_clr(bClr), .o_err(bErr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Event log of DUT A: B=table_back, S=table_start, O=grip opens,
    // C=grip closes, D=done.
    string       evLog = "";
    int          doneCount = 0, clrCount = 0, startCyc = 0, doneCyc = 0;
    logic [31:0] lastDest = '0, graspX = '0, graspY = '0;
    logic        prevGrip = 1'b0;
    bit          graspSeen = 0;
    int          holdCycles = 0;
    bit          stuckOnStart = 0;
    int          busyLeft = 0;

    // Monitor and slide-table model, sampled 1 time unit after each edge.
    // After every table pulse the table reports busy for holdCycles cycles
    // (or forever on a start pulse when stuckOnStart is set).
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (aBack) evLog = {evLog, "B"};
            if (aStart) begin
                evLog = {evLog, "S"};
                lastDest = aDest;
                startCyc = cyc;
            end
            if (aGrip && !prevGrip) evLog = {evLog, "O"};
            if (!aGrip && prevGrip) begin
                evLog = {evLog, "C"};
                if (!graspSeen) begin
                    graspSeen = 1;
                    graspX = aArmX;
                    graspY = aArmY;
                end
            end
            if (aDone) begin
                evLog = {evLog, "D"};
                doneCount++;
                doneCyc = cyc;
            end
            if (aClr) clrCount++;
            prevGrip = aGrip;
            if (aStart && stuckOnStart) busyLeft = 1000;
            else if (aStart || aBack) busyLeft = holdCycles;
            else if (busyLeft > 0) busyLeft--;
            tableBusy = (busyLeft > 0);
        end
    end

    // Test code samples and drives 2 time units after the edge, after the
    // monitor has updated.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, wanted %b", name, actual, expected);
        end
    endtask

    task automatic checkLog(input string name, input string actual, input string expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got \"%s\", wanted \"%s\"", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out, got no event, wanted one", name);
    endtask

    task automatic clearLog();
        evLog = "";
        doneCount = 0;
        clrCount = 0;
        graspSeen = 0;
    endtask

    // Offer a job and return the edge that starts the handshake cycle.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                                 output int acceptCyc);
        bit readyBefore;
        bit taken;
        taken = 0;
        acceptCyc = 0;
        jobX = x;
        jobY = y;
        jobZ = z;
        jobValid = 1'b1;
        for (int i = 0; i < 60 && !taken; i++) begin
            readyBefore = aReady;
            tick();
            if (readyBefore) begin
                taken = 1;
                acceptCyc = cyc - 1;
            end
        end
        jobValid = 1'b0;
        if (!taken) failTimeout("jobAccept");
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (doneCount > 0) seen = 1;
        end
        if (!seen) failTimeout("waitDone");
    endtask

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] hold;
        logic [31:0] expLat;
    } jobVec_t;

    jobVec_t vecs [4];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  acc;
        int  errCyc;
        int  logLen;
        bit  seen;
        int  gripHigh, armHit, pulsesB, bDoneCyc;
        bit  doneB;
        logic clrWithDone;

        // Latency = 3*(1+max(hold,T_BLANK)) + 3*T_GRIP + 3*T_ARM + 1
        vecs[0] = '{32'h0005_0000, 32'h000A_0000, 32'h0003_0000, 32'd10, 32'd58};
        vecs[1] = '{32'h0001_8000, 32'h0002_4000, 32'h0000_0000, 32'd0,  32'd34};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'd2,  32'd34};
        vecs[3] = '{32'h1234_5678, 32'h0BAD_F00D, 32'h0007_C000, 32'd3,  32'd37};

        // Reset state
        tick(); tick(); tick();
        checkBit("rstReady", aReady, 1'b0);
        checkBit("rstBusy", aBusy, 1'b0);
        checkBit("rstGrip", aGrip, 1'b0);
        checkBit("rstArmEn", aArmEn, 1'b1);
        checkBit("rstErr", aErr, 1'b0);
        checkOutput("rstArmY", aArmY, HOME_Y);
        checkOutput("rstDest", aDest, 32'd0);
        reset = 1'b0;
        tick();
        checkBit("readyAfterRst", aReady, 1'b1);

        // Table-driven normal jobs
        for (int v = 0; v < 4; v++) begin
            holdCycles = int'(vecs[v].hold);
            clearLog();
            applyStimulus(vecs[v].x, vecs[v].y, vecs[v].z, acc);
            checkBit($sformatf("v%0d busyOnAccept", v), aBusy, 1'b1);
            checkBit($sformatf("v%0d backOnAccept", v), aBack, 1'b1);
            waitDone(200);
            tick();
            checkLog($sformatf("v%0d order", v), evLog, "BSOCBOCD");
            checkOutput($sformatf("v%0d latency", v), doneCyc - acc, vecs[v].expLat);
            checkOutput($sformatf("v%0d dest", v), lastDest, vecs[v].z);
            checkOutput($sformatf("v%0d reachX", v), graspX, vecs[v].x);
            checkOutput($sformatf("v%0d reachY", v), graspY, vecs[v].y);
            checkOutput($sformatf("v%0d doneCount", v), doneCount, 32'd1);
            checkOutput($sformatf("v%0d clrCount", v), clrCount, 32'd1);
            checkBit($sformatf("v%0d busyAfter", v), aBusy, 1'b0);
            checkBit($sformatf("v%0d readyAfter", v), aReady, 1'b1);
            checkOutput($sformatf("v%0d stowX", v), aArmX, 32'd0);
            checkOutput($sformatf("v%0d stowY", v), aArmY, HOME_Y);
        end

        // Table stuck busy in MOVE -> FAULT 40 cycles after the start pulse
        clearLog();
        holdCycles = 0;
        stuckOnStart = 1;
        applyStimulus(32'h0002_0000, 32'h0002_0000, 32'h0009_0000, acc);
        seen = 0;
        errCyc = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (aErr) begin
                seen = 1;
                errCyc = cyc;
            end
        end
        if (!seen) failTimeout("faultEntry");
        checkOutput("faultDelay", errCyc - startCyc, 32'd40);
        checkBit("faultGrip", aGrip, 1'b0);
        checkBit("faultBusy", aBusy, 1'b1);
        checkOutput("faultArmY", aArmY, HOME_Y);
        logLen = evLog.len();
        tick(); tick(); tick();
        checkOutput("faultNoPulses", evLog.len(), logLen);
        checkBit("faultHeld", aErr, 1'b1);
        abortReq = 1'b1;
        tick();
        abortReq = 1'b0;
        stuckOnStart = 0;
        busyLeft = 0;
        checkBit("faultClearErr", aErr, 1'b0);
        checkBit("faultClearReady", aReady, 1'b1);
        checkBit("faultClearBusy", aBusy, 1'b0);
        tick();

        // Abort in REACH -> RECOVER with a fresh table_back, no done
        clearLog();
        holdCycles = 0;
        applyStimulus(32'h0004_0000, 32'h0006_0000, 32'h0001_0000, acc);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (aArmX == 32'h0004_0000) seen = 1;
        end
        if (!seen) failTimeout("reachEntry");
        holdCycles = 4;
        abortReq = 1'b1;
        tick();
        abortReq = 1'b0;
        checkBit("recoverBack", aBack, 1'b1);
        checkBit("recoverGrip", aGrip, 1'b0);
        checkBit("recoverBusy", aBusy, 1'b1);
        checkOutput("recoverArmX", aArmX, 32'd0);
        checkOutput("recoverArmY", aArmY, HOME_Y);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkBit($sformatf("recoverWait%0d", i), aReady, 1'b0);
        end
        tick();
        checkBit("recoverReady", aReady, 1'b1);
        checkBit("recoverIdleBusy", aBusy, 1'b0);
        checkOutput("recoverNoDone", doneCount, 32'd0);
        holdCycles = 0;

        // abort together with job_valid in IDLE: job accepted, abort ignored
        clearLog();
        jobX = 32'h0003_0000;
        jobY = 32'h0004_0000;
        jobZ = 32'h0002_0000;
        jobValid = 1'b1;
        abortReq = 1'b1;
        tick();
        jobValid = 1'b0;
        abortReq = 1'b0;
        acc = cyc - 1;
        checkBit("bothBack", aBack, 1'b1);
        checkBit("bothReady", aReady, 1'b0);
        tick();
        checkBit("bothNoRepulse", aBack, 1'b0);
        waitDone(200);
        checkLog("bothOrder", evLog, "BSOCBOCD");
        checkOutput("bothLatency", doneCyc - acc, 32'd34);
        tick();

        // Reset in GRASP, then a clean job
        clearLog();
        applyStimulus(32'h0002_0000, 32'h0003_0000, 32'h0005_0000, acc);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (aGrip) seen = 1;
        end
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (!aGrip) seen = 1;
        end
        if (!seen) failTimeout("graspEntry");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkBit("midRstReady", aReady, 1'b0);
        checkBit("midRstStart", aStart, 1'b0);
        checkBit("midRstBack", aBack, 1'b0);
        checkOutput("midRstDest", aDest, 32'd0);
        checkOutput("midRstArmX", aArmX, 32'd0);
        checkOutput("midRstArmY", aArmY, HOME_Y);
        checkBit("midRstArmEn", aArmEn, 1'b1);
        checkBit("midRstGrip", aGrip, 1'b0);
        checkBit("midRstBusy", aBusy, 1'b0);
        checkBit("midRstDone", aDone, 1'b0);
        checkBit("midRstClr", aClr, 1'b0);
        checkBit("midRstErr", aErr, 1'b0);
        tick();
        checkBit("midRstReadyNext", aReady, 1'b1);
        clearLog();
        applyStimulus(32'h0006_0000, 32'h0001_0000, 32'h0004_0000, acc);
        waitDone(200);
        checkLog("postRstOrder", evLog, "BSOCBOCD");
        checkOutput("postRstLatency", doneCyc - acc, 32'd34);
        checkOutput("postRstDest", lastDest, 32'h0004_0000);

        // Zero dwells on DUT B: each dwell state lasts one cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clearLog();
        holdCycles = 0;
        applyStimulus(32'h0007_0000, 32'h0008_0000, 32'h000B_0000, acc);
        gripHigh = 0;
        armHit = 0;
        bDoneCyc = 0;
        doneB = 0;
        clrWithDone = 1'b0;
        pulsesB = int'(bBack) + int'(bStart);
        for (int i = 0; i < 100 && !doneB; i++) begin
            tick();
            if (bGrip) gripHigh++;
            if (bArmX == 32'h0007_0000) armHit++;
            pulsesB += int'(bBack) + int'(bStart);
            if (bDone) begin
                doneB = 1;
                bDoneCyc = cyc;
                clrWithDone = bClr;
            end
        end
        if (!doneB) failTimeout("zeroDwellDone");
        checkOutput("zeroLatency", bDoneCyc - acc, 32'd16);
        checkOutput("zeroGripCycles", gripHigh, 32'd3);
        checkOutput("zeroArmCycles", armHit, 32'd2);
        checkOutput("zeroPulses", pulsesB, 32'd3);
        checkBit("zeroClr", clrWithDone, 1'b1);
        checkOutput("zeroDest", bDest, 32'h000B_0000);
        tick();
        checkBit("zeroBusyAfter", bBusy, 1'b0);
        checkBit("zeroReadyAfter", bReady, 1'b1);
        checkBit("zeroErr", bErr, 1'b0);
        checkBit("zeroArmEn", bArmEn, 1'b1);
        checkBit("zeroGripAfter", bGrip, 1'b0);
        checkOutput("zeroArmY", bArmY, HOME_Y);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pick_seq_ctrl.md
# pick_seq_ctrl

Event-driven sequencer for one pick-and-place job on the robot cell. It accepts a target (x, y, z) over a valid/ready handshake. It drives the slide-table command pins, the arm inverse-kinematics inputs and the gripper through a fixed step list. Each table move is closed-loop on the table busy signal with a timeout; each arm or gripper step has a programmable dwell. It sits between the UART/voice command front end and the arm, slide-table and gripper drivers.

## Interface
- T_ARM, 32'd50_000_000, arm settle dwell in cycles (0 treated as 1)
- T_GRIP, 32'd25_000_000, gripper settle dwell in cycles (0 treated as 1)
- T_TABLE, 32'd500_000_000, table move timeout in cycles from command pulse
- T_BLANK, 8'd4, cycles after a table pulse during which table_busy is ignored
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  controller can accept job
- job_x, job_y, job_z  in  32  target, Q16.16 cm
- abort  in  1  level; cancel current job
- table_busy  in  1  slide table moving
- table_start  out  1  one-cycle active-high start pulse (table_dest valid)
- table_back  out  1  one-cycle active-high homing pulse
- table_dest  out  32  table destination, Q16.16 cm
- arm_x, arm_y  out  32  IK target, Q16.16 cm
- arm_en  out  1  1 = arm follows arm_x/arm_y
- grip  out  1  1 = gripper open
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, job completed
- job_clr  out  1  one-cycle pulse with done; clears upstream command latch
- err  out  1  high in FAULT

## Operation
- All outputs are registered. Reset values: job_ready=0, table_start=0, table_back=0, table_dest=0, arm_x=0, arm_y=HOME_Y, arm_en=1, grip=0, busy=0, done=0, job_clr=0, err=0, state=IDLE.
- IDLE: job_ready=1. Accept when job_valid && job_ready. Latch x/y/z that cycle and go to HOME.
- HOME: table_back pulse, then table wait.
- MOVE: table_dest=z, table_start pulse, then table wait.
- OPEN: grip=1, dwell T_GRIP.
- REACH: arm_x/arm_y=job x/y, dwell T_ARM.
- GRASP: grip=0, dwell T_GRIP.
- PARK: arm_x/arm_y=PARK_X/PARK_Y, dwell T_ARM.
- RETURN: table_back pulse, then table wait.
- RELEASE: grip=1, dwell T_GRIP.
- STOW: grip=0, arm_x=0, arm_y=HOME_Y, dwell T_ARM.
- DONE: done and job_clr pulse, then IDLE.
- Table wait: the timer starts on the pulse cycle. table_busy is ignored for T_BLANK cycles. The step completes on the first sampled table_busy=0 after blanking. A timer reaching T_TABLE first goes to FAULT.
- abort high in any state other than IDLE, FAULT or RECOVER goes to RECOVER. RECOVER: grip=0, arm stowed, table_back pulse, table wait, then IDLE. No done pulse. A timeout in RECOVER goes to FAULT.
- FAULT: err=1, grip=0, arm stowed, no table pulses. Exits to IDLE only on abort=1, which clears err.
- Arithmetic: 32-bit unsigned step timer; no wrap possible below 2^32−1. Coordinates pass through unmodified.

## Timing
- Job accepted on edge N: busy=1 and table_back=1 on edge N+1. job_ready=0 from N+1 until the cycle after DONE.
- Dwell of D cycles: the state is occupied for exactly max(D,1) cycles, with outputs updated on the entry edge.
- Minimum job latency with table_busy held 0: 3·(1+T_BLANK) + 3·T_GRIP + 3·T_ARM + 1 cycles, accept edge to done.
- Simultaneous events:
  - abort and job_valid in IDLE: the job is accepted and abort is ignored.
  - abort and timeout in the same cycle: abort wins (RECOVER).
  - abort during the T_BLANK window: RECOVER, with a new table_back pulse.
- rst mid-operation: all outputs reach their reset values on the next edge. In-flight pulses are truncated. The latched job is discarded.

## Structure
- Package pick_seq_pkg holds:
  - the state enum: IDLE, HOME, MOVE, OPEN, REACH, GRASP, PARK, RETURN, RELEASE, STOW, DONE, RECOVER, FAULT
  - Q16.16 constants HOME_Y=32'h0019_6666 (L1+L2), PARK_X=32'd289057, PARK_Y=32'd1639325
- One sub-module, step_timer: load/clear, count enable, compare against a 32-bit limit, expired flag. It is shared by dwell and timeout.

## Test plan
1. Parameters T_ARM=5, T_GRIP=3, T_BLANK=2. Job x=0x0005_0000, y=0x000A_0000, z=0x0003_0000; table_busy=1 for 10 cycles after each pulse. Required: pulse order back, start(dest=0x0003_0000), back; grip 1→0→1→0; one done+job_clr; busy falls after done.
2. table_busy stuck at 1 in MOVE with T_TABLE=40 → FAULT exactly 40 cycles after the table_start pulse, err=1, grip=0. Then abort=1 → IDLE, err=0.
3. abort asserted in REACH → RECOVER, table_back pulse next cycle, arm stowed, no done, job_ready=1 after table idle.
4. abort and job_valid both high in IDLE → job accepted, HOME entered, no RECOVER.
5. rst asserted in GRASP for 1 cycle → all outputs at reset values next edge. job_ready=1 the following cycle. A new job completes normally.
6. T_ARM=0 and T_GRIP=0 → each dwell state lasts exactly 1 cycle; latency matches the formula.
